// File: rtl/encrypt_round_ctrl_if.sv
// rtl/encrypt_round_ctrl_if.sv - operand/result handshake bundle for encrypt_round_ctrl (mode signal present when DECRYPT_EN is defined)
interface encrypt_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] number;
    logic [7:0] key;
`ifdef DECRYPT_EN
    logic       mode;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] enc_number;

    modport master (
        output in_valid,
        output number,
        output key,
`ifdef DECRYPT_EN
        output mode,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  enc_number
    );

    modport slave (
        input  in_valid,
        input  number,
        input  key,
`ifdef DECRYPT_EN
        input  mode,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output enc_number
    );
endinterface

// File: rtl/encrypt_round_ctrl.sv
// rtl/encrypt_round_ctrl.sv - iterative nibble-Feistel round controller, one round per clock; DECRYPT_EN adds a reversed key schedule selected by mode
module encrypt_round_ctrl #(
    parameter int ROUNDS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    encrypt_round_ctrl_if.slave  bus,
    output logic                 busy,
    output logic [3:0]           round_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] l_q, l_d;
    logic [3:0] r_q, r_d;
    logic [7:0] key_q, key_d;
    logic [7:0] enc_q, enc_d;
`ifdef DECRYPT_EN
    logic       mode_q, mode_d;
`endif

    logic [2:0]  rot_amt;
    logic [15:0] rot_wide;
    logic [7:0]  round_key;
    logic [7:0]  expand;
    logic [7:0]  mix;
    logic [3:0]  s_val;
    logic [3:0]  l_new;
    logic        is_last;

    // Round key: master key rotated left; decrypt walks the schedule backwards
    always_comb begin
`ifdef DECRYPT_EN
        rot_amt = mode_q ? (LAST[2:0] - cnt_q[2:0]) : cnt_q[2:0];
`else
        rot_amt = cnt_q[2:0];
`endif
        rot_wide  = {key_q, key_q} << rot_amt;
        round_key = rot_wide[15:8];
    end

    // Shared round function: expand R, mix with key, fold nibbles, xor into L
    always_comb begin
        expand  = {r_q[0], r_q[3], r_q[2], r_q[1], r_q[2], r_q[1], r_q[0], r_q[3]};
        mix     = expand ^ round_key;
        s_val   = mix[7:4] + mix[3:0] + {3'b000, round_key[0]};
        l_new   = l_q ^ s_val;
        is_last = (cnt_q == LAST);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        key_d   = key_q;
        enc_d   = enc_q;
`ifdef DECRYPT_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    l_d     = bus.number[7:4];
                    r_d     = bus.number[3:0];
                    key_d   = bus.key;
                    cnt_d   = 4'd0;
`ifdef DECRYPT_EN
                    mode_d  = bus.mode;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_last) begin
                    // Final round keeps the halves in place
                    l_d     = l_new;
                    enc_d   = {l_new, r_q};
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    l_d   = r_q;
                    r_d   = l_new;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            l_q     <= 4'd0;
            r_q     <= 4'd0;
            key_q   <= 8'd0;
            enc_q   <= 8'd0;
`ifdef DECRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            key_q   <= key_d;
            enc_q   <= enc_d;
`ifdef DECRYPT_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.enc_number = enc_q;
        busy           = (state_q != IDLE);
        round_idx      = (state_q == RUN) ? cnt_q : 4'd0;
    end

endmodule

// File: tb/tb_encrypt_round_ctrl.sv
// tb/tb_encrypt_round_ctrl.sv - directed self-checking bench for encrypt_round_ctrl at ROUNDS=1, 2 and 4
module tb_encrypt_round_ctrl;

    logic       clock;
    logic       reset;
    logic [2:0] iv;
    logic [7:0] number;
    logic [7:0] key;
    logic       out_ready;
    logic       mode;

    int total;
    int passed;

    encrypt_round_ctrl_if if1 ();
    encrypt_round_ctrl_if if2 ();
    encrypt_round_ctrl_if if4 ();

    logic [2:0] busy_v;
    logic [3:0] ridx0, ridx1, ridx2;

    assign if1.in_valid  = iv[0];
    assign if2.in_valid  = iv[1];
    assign if4.in_valid  = iv[2];
    assign if1.number    = number;
    assign if2.number    = number;
    assign if4.number    = number;
    assign if1.key       = key;
    assign if2.key       = key;
    assign if4.key       = key;
    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;
    assign if4.out_ready = out_ready;
`ifdef DECRYPT_EN
    assign if1.mode = mode;
    assign if2.mode = mode;
    assign if4.mode = mode;
`endif

    encrypt_round_ctrl #(.ROUNDS(1)) u1 (
        .clock(clock), .reset(reset), .bus(if1.slave), .busy(busy_v[0]), .round_idx(ridx0)
    );
    encrypt_round_ctrl #(.ROUNDS(2)) u2 (
        .clock(clock), .reset(reset), .bus(if2.slave), .busy(busy_v[1]), .round_idx(ridx1)
    );
    encrypt_round_ctrl #(.ROUNDS(4)) u4 (
        .clock(clock), .reset(reset), .bus(if4.slave), .busy(busy_v[2]), .round_idx(ridx2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic get_ov(input int sel);
        case (sel)
            0: return if1.out_valid;
            1: return if2.out_valid;
            default: return if4.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            0: return if1.in_ready;
            1: return if2.in_ready;
            default: return if4.in_ready;
        endcase
    endfunction

    function automatic logic [7:0] get_enc(input int sel);
        case (sel)
            0: return if1.enc_number;
            1: return if2.enc_number;
            default: return if4.enc_number;
        endcase
    endfunction

    function automatic logic [3:0] get_ridx(input int sel);
        case (sel)
            0: return ridx0;
            1: return ridx1;
            default: return ridx2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Accept one operand, step through every round, then drain with out_ready held high
    task automatic run_op(input int sel, input int rounds, input logic [7:0] num,
                          input logic [7:0] k, input logic [7:0] exp_enc);
        number    = num;
        key       = k;
        out_ready = 1'b1;
        iv[sel]   = 1'b1;
        tick();
        iv[sel]   = 1'b0;
        number    = ~num;
        key       = ~k;
        for (int i = 0; i < rounds; i++) begin
            check($sformatf("s%0d_ridx%0d", sel, i), 32'(get_ridx(sel)), 32'(i));
            check($sformatf("s%0d_ov_run%0d", sel, i), 32'(get_ov(sel)), 32'd0);
            check($sformatf("s%0d_busy_run%0d", sel, i), 32'(busy_v[sel]), 32'd1);
            tick();
        end
        check($sformatf("s%0d_ov_done", sel), 32'(get_ov(sel)), 32'd1);
        check($sformatf("s%0d_enc", sel), 32'(get_enc(sel)), 32'(exp_enc));
        check($sformatf("s%0d_ridx_done", sel), 32'(get_ridx(sel)), 32'd0);
        tick();
        check($sformatf("s%0d_ov_idle", sel), 32'(get_ov(sel)), 32'd0);
        check($sformatf("s%0d_ir_idle", sel), 32'(get_ir(sel)), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset     = 1'b1;
        iv        = 3'b000;
        number    = 8'h00;
        key       = 8'h00;
        out_ready = 1'b0;
        mode      = 1'b0;
        tick();
        tick();

        check("rst_in_ready", 32'(if4.in_ready), 32'd1);
        check("rst_out_valid", 32'(if4.out_valid), 32'd0);
        check("rst_busy", 32'(busy_v[2]), 32'd0);
        check("rst_round_idx", 32'(ridx2), 32'd0);
        check("rst_enc", 32'(if4.enc_number), 32'h00);
        reset = 1'b0;
        tick();

        run_op(0, 1, 8'h00, 8'h01, 8'h20);
        run_op(0, 1, 8'h0F, 8'h00, 8'hEF);
        run_op(1, 2, 8'h00, 8'h01, 8'h72);
        run_op(2, 4, 8'h00, 8'h01, 8'h67);
        run_op(2, 4, 8'h0F, 8'h00, 8'h1A);

        // Back-pressure on the ROUNDS=2 instance, with a competing in_valid held high
        number = 8'h00;
        key    = 8'h01;
        iv[1]  = 1'b1;
        tick();
        number = 8'h5A;
        key    = 8'hC3;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_ov%0d", i), 32'(if2.out_valid), 32'd1);
            check($sformatf("bp_enc%0d", i), 32'(if2.enc_number), 32'h72);
            check($sformatf("bp_ir%0d", i), 32'(if2.in_ready), 32'd0);
            tick();
        end
        iv[1]     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ov", 32'(if2.out_valid), 32'd0);
        check("bp_release_ir", 32'(if2.in_ready), 32'd1);
        check("bp_release_busy", 32'(busy_v[1]), 32'd0);
        check("bp_release_enc", 32'(if2.enc_number), 32'h72);
        tick();
        check("bp_no_accept", 32'(busy_v[1]), 32'd0);

        // Reset in the middle of a ROUNDS=4 operation
        number = 8'h00;
        key    = 8'h01;
        iv[2]  = 1'b1;
        tick();
        iv[2]  = 1'b0;
        tick();
        check("mid_ridx1", 32'(ridx2), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ir", 32'(if4.in_ready), 32'd1);
        check("mid_rst_ov", 32'(if4.out_valid), 32'd0);
        check("mid_rst_enc", 32'(if4.enc_number), 32'h00);
        check("mid_rst_busy", 32'(busy_v[2]), 32'd0);
        check("mid_rst_ridx", 32'(ridx2), 32'd0);
        tick();
        check("mid_rst_stays_idle", 32'(busy_v[2]), 32'd0);
        run_op(2, 4, 8'h0F, 8'h00, 8'h1A);

`ifdef DECRYPT_EN
        mode = 1'b1;
        run_op(1, 2, 8'h72, 8'h01, 8'h00);
        mode = 1'b0;
        run_op(1, 2, 8'h00, 8'h01, 8'h72);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
